// File: rtl/input_packet_fifo.sv
// ============================================================================
// input_packet_fifo : first-word-fall-through packet FIFO feeding the grid west port
// Revision: 1.0
// ============================================================================
`default_nettype none

module input_packet_fifo #(
  parameter int DATA_WIDTH = 30,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wen,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic                          full,
  output logic                          almost_full,
  input  logic                          ren,
  output logic                          empty,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          clear_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];
  localparam logic [AW:0] AF_CNT    = AF_LEVEL[AW:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;
  logic                  ovf_event;
  logic                  unf_event;

  // Flags decode only from the registered count, never from wen/ren.
  assign empty       = (count == '0);
  assign full        = (count == DEPTH_CNT);
  assign almost_full = (count >= AF_CNT);
  assign dout        = mem[rd_ptr];

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_pop    = ren && !empty;
  assign do_push   = wen && (!full || do_pop);
  assign ovf_event = wen && full && !ren;
  assign unf_event = ren && empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new error event wins over a coincident clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_event || (overflow && !clear_err);
      underflow <= unf_event || (underflow && !clear_err);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_input_packet_fifo.sv
// Directed self-checking bench for input_packet_fifo (DEPTH=16, DATA_WIDTH=30).
`timescale 1ns/1ps
`default_nettype none

module tb_input_packet_fifo;

  localparam int DW    = 30;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset_n;
  logic          wen;
  logic [DW-1:0] din;
  logic          full;
  logic          almost_full;
  logic          ren;
  logic          empty;
  logic [DW-1:0] dout;
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;
  logic          clear_err;

  int n_assert = 0;
  int n_fail   = 0;

  input_packet_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(DEPTH-2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wen         (wen),
    .din         (din),
    .full        (full),
    .almost_full (almost_full),
    .ren         (ren),
    .empty       (empty),
    .dout        (dout),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .clear_err   (clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are checked at that point too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [DW-1:0] grid_exp [5];
  int            gi;

  initial begin
    reset_n   = 1'b0;
    wen       = 1'b0;
    ren       = 1'b0;
    din       = '0;
    clear_err = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);

    // Three writes then three pops; first write lands on the first edge after release
    reset_n = 1'b1;
    wen = 1'b1; din = 30'd1; tick();
    chk("w1_dout", 32'(dout), 32'd1);
    chk("w1_empty", 32'(empty), 32'd0);
    din = 30'd2; tick();
    din = 30'd3; tick();
    wen = 1'b0;
    chk("w3_count", 32'(count), 32'd3);
    ren = 1'b1;
    chk("pop_a", 32'(dout), 32'd1);
    tick();
    chk("pop_b", 32'(dout), 32'd2);
    tick();
    chk("pop_c", 32'(dout), 32'd3);
    tick();
    ren = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_unf", 32'(underflow), 32'd0);

    // Fill to DEPTH, checking almost_full threshold at 14
    wen = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      din = DW'(32'h100 + i);
      tick();
      chk($sformatf("fill_af_%0d", i + 1), 32'(almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    din = 30'h3FF; tick();
    wen = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(dout), 32'h100);
    chk("ovf_count", 32'(count), 32'd16);
    clear_err = 1'b1; tick();
    clear_err = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Full, simultaneous push/pop for 20 cycles across the pointer wrap
    wen = 1'b1; ren = 1'b1;
    for (int k = 0; k < 20; k++) begin
      din = DW'(32'h200 + k);
      chk($sformatf("thru_dout_%0d", k), 32'(dout), (k < 16) ? (32'h100 + k) : (32'h200 + k - 16));
      tick();
      chk($sformatf("thru_count_%0d", k), 32'(count), 32'd16);
    end
    wen = 1'b0;
    chk("thru_ovf", 32'(overflow), 32'd0);
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("tail_dout_%0d", j), 32'(dout), 32'h204 + j);
      tick();
    end
    ren = 1'b0;
    chk("tail_empty", 32'(empty), 32'd1);
    chk("tail_unf", 32'(underflow), 32'd0);

    // Simultaneous write/read on empty: push only, underflow sets
    wen = 1'b1; ren = 1'b1; din = 30'h2AAAAAAA; tick();
    wen = 1'b0; ren = 1'b0;
    chk("we_count", 32'(count), 32'd1);
    chk("we_unf", 32'(underflow), 32'd1);
    chk("we_dout", 32'(dout), 32'h2AAAAAAA);
    clear_err = 1'b1; tick();
    clear_err = 1'b0;
    chk("we_unf_clr", 32'(underflow), 32'd0);
    ren = 1'b1; tick();
    chk("we_pop_empty", 32'(empty), 32'd1);
    chk("we_pop_unf", 32'(underflow), 32'd0);
    tick();
    chk("unf_empty_pop", 32'(underflow), 32'd1);
    chk("unf_count", 32'(count), 32'd0);
    clear_err = 1'b1; tick();
    chk("unf_clr_coincide", 32'(underflow), 32'd1);
    ren = 1'b0; tick();
    clear_err = 1'b0;
    chk("unf_clr", 32'(underflow), 32'd0);

    // Asynchronous reset mid-operation
    wen = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = DW'(32'h40 + i);
      tick();
    end
    chk("pre_rst_count", 32'(count), 32'd5);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_count", 32'(count), 32'd0);
    din = 30'h77; tick();
    chk("arst_wen_ignored", 32'(count), 32'd0);
    reset_n = 1'b1;
    din = 30'h55; tick();
    wen = 1'b0;
    chk("post_rst_dout", 32'(dout), 32'h55);
    chk("post_rst_count", 32'(count), 32'd1);

    // Grid-style drain: load 4 more, consumer pops whenever not empty
    wen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = DW'(32'h61 + i);
      tick();
    end
    wen = 1'b0;
    grid_exp[0] = 30'h55;
    for (int i = 0; i < 4; i++) grid_exp[i+1] = DW'(32'h61 + i);
    gi = 0;
    for (int c = 0; c < 20; c++) begin
      if (empty) break;
      if (gi < 5) chk($sformatf("grid_dout_%0d", gi), 32'(dout), 32'(grid_exp[gi]));
      ren = 1'b1;
      tick();
      ren = 1'b0;
      gi++;
    end
    chk("grid_popped", 32'(gi), 32'd5);
    chk("grid_empty", 32'(empty), 32'd1);
    chk("grid_unf", 32'(underflow), 32'd0);
    chk("grid_ovf", 32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/input_packet_fifo.md
INPUT_PACKET_FIFO -- requirements
Module: input_packet_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 30, packet width (dx 9, dy 9, axon 8, tick 4).
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, minimum 2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts.
REQ-004 SHALL have derived localparam AW = log2(DEPTH).
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port wen  input  1  host write request.
REQ-008 SHALL have port din  input  DATA_WIDTH  host write packet.
REQ-009 SHALL have port full  output  1  occupancy == DEPTH.
REQ-010 SHALL have port almost_full  output  1  occupancy >= AF_LEVEL.
REQ-011 SHALL have port ren  input  1  grid pop request (driven from the grid's west read-enable).
REQ-012 SHALL have port empty  output  1  occupancy == 0 (drives the grid's west empty input).
REQ-013 SHALL have port dout  output  DATA_WIDTH  head packet (drives the grid's west packet input).
REQ-014 SHALL have port count  output  AW+1  current occupancy.
REQ-015 SHALL have port overflow  output  1  sticky: write attempted while full.
REQ-016 SHALL have port underflow  output  1  sticky: pop attempted while empty.
REQ-017 SHALL have port clear_err  input  1  synchronous clear of overflow/underflow.

Function
REQ-018 SHALL be first-word-fall-through: dout equals the oldest stored packet whenever empty=0, with no read latency.
REQ-019 SHALL pop the head on a rising edge where ren=1 and empty=0; the next entry is on dout in the following cycle.
REQ-020 SHALL push din on a rising edge where wen=1 and full=0; a packet written into an empty FIFO SHALL appear on dout and deassert empty one cycle after the write edge.
REQ-021 SHALL hold dout stable while ren=0; its value SHALL be don't-care while empty=1.
REQ-022 SHALL use AW-bit read/write pointers that wrap modulo DEPTH, plus an AW+1-bit count; full, empty, and almost_full SHALL be registered-state decodes of count, combinational from registers only.
REQ-023 Simultaneous wen and ren with 0<count<DEPTH: both SHALL occur and count SHALL be unchanged.
REQ-024 Simultaneous wen and ren when full: pop and push SHALL both occur, count SHALL stay DEPTH, and overflow SHALL NOT set.
REQ-025 Simultaneous wen and ren when empty: push SHALL occur, pop SHALL be ignored (no bypass), count SHALL become 1, and underflow SHALL set.
REQ-026 wen while full without ren: din SHALL be dropped, state unchanged, overflow SHALL set the next cycle.
REQ-027 ren while empty without wen: no state change; underflow SHALL set the next cycle.
REQ-028 overflow and underflow SHALL remain set until clear_err=1 or reset; if clear_err coincides with a new error event, the flag SHALL remain set.
REQ-029 Storage SHALL be a register array without reset; only pointers, count, and flags are reset.

Reset
REQ-030 On reset_n low, asynchronously: pointers=0, count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored packets; wen/ren SHALL be ignored while reset_n=0.
REQ-032 The first write SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-033 Reset, then write 0x0000_0001..0x0000_0003 (one per cycle), then ren for 3 cycles -> dout sequence 1,2,3; empty=1 and count=0 after the third pop; underflow=0.
REQ-034 Write 16 packets with DEPTH=16 -> full=1, count=16, almost_full asserted when count reaches 14; a 17th write -> dropped, overflow=1, head still the first packet.
REQ-035 Full FIFO, wen=1 and ren=1 for 20 cycles with an incrementing din -> count stays 16, overflow=0, pops emerge in order across pointer wrap.
REQ-036 Empty FIFO, wen=1 din=0x2AAAAAAA with ren=1 in the same cycle -> count=1, underflow=1, dout=0x2AAAAAAA next cycle; clear_err pulse -> underflow=0.
REQ-037 Load 5 packets, assert reset_n low between clock edges -> empty=1 and count=0 immediately without a clock edge; after release, a new write appears on dout one cycle later.
REQ-038 Connect to the 1x1 grid west port, load 4 packets while tick is pulsed -> the grid drains all 4 through ren, empty=1 afterwards, and no scheduler or token-controller error is raised.
